// File: rtl/control_bus_param.sv
// Single-master bus controller: latches a read/write request, runs
// SETUP and ACCESS phases with a ready handshake and an ACCESS timeout.
module control_bus_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_Inicio,
    input  logic [1:0]        Control_Salida,
    input  logic [DATA_W-1:0] Num8b,
    input  logic [DATA_W-1:0] RX,
    input  logic [DATA_W-1:0] RY,
    input  logic              i_Listo,
    input  logic [DATA_W-1:0] i_Bus_Datos_E,
    output logic [DATA_W-1:0] o_Bus_Datos_S,
    output logic [ADDR_W-1:0] o_Bus_Direccion_Datos,
    output logic              o_Lectura_Escritura,
    output logic              o_Habilitacion,
    output logic              o_Ocupado,
    output logic              o_Hecho,
    output logic              o_Error,
    output logic [DATA_W-1:0] o_Dato_Leido
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                   state_q;
    logic [CW-1:0]            cnt_q;
    logic                     rd_q;
    logic [DATA_W-1:0]        sel_d;
    logic [DATA_W-1:0]        wdata_d;
    logic [ADDR_W+DATA_W-1:0] addr_ext;

    always_comb begin
        sel_d   = RX;
        wdata_d = '0;
        case (Control_Salida)
            2'b01:   sel_d   = RY;
            2'b10:   wdata_d = Num8b;
            2'b11:   wdata_d = RY;
            default: wdata_d = '0;
        endcase
    end

    // Zero-extend first so a narrower or wider address bus both work.
    assign addr_ext = {{ADDR_W{1'b0}}, sel_d};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q               <= IDLE;
            cnt_q                 <= '0;
            rd_q                  <= 1'b0;
            o_Bus_Datos_S         <= '0;
            o_Bus_Direccion_Datos <= '0;
            o_Lectura_Escritura   <= 1'b0;
            o_Habilitacion        <= 1'b0;
            o_Ocupado             <= 1'b0;
            o_Hecho               <= 1'b0;
            o_Error               <= 1'b0;
            o_Dato_Leido          <= '0;
        end else begin
            o_Hecho <= 1'b0;
            o_Error <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_Inicio && Control_Salida != 2'b00) begin
                        state_q               <= SETUP;
                        o_Ocupado             <= 1'b1;
                        o_Bus_Direccion_Datos <= addr_ext[ADDR_W-1:0];
                        o_Bus_Datos_S         <= wdata_d;
                        o_Lectura_Escritura   <= Control_Salida[1];
                        rd_q                  <= (Control_Salida == 2'b01);
                    end
                end
                SETUP: begin
                    state_q        <= ACCESS;
                    o_Habilitacion <= 1'b1;
                    cnt_q          <= '0;
                end
                ACCESS: begin
                    // Ready on the final counted cycle still wins over timeout.
                    if (i_Listo || cnt_q == LAST) begin
                        state_q               <= DONE;
                        cnt_q                 <= '0;
                        o_Habilitacion        <= 1'b0;
                        o_Bus_Datos_S         <= '0;
                        o_Bus_Direccion_Datos <= '0;
                        o_Lectura_Escritura   <= 1'b0;
                        o_Hecho               <= 1'b1;
                        o_Error               <= !i_Listo;
                        if (i_Listo && rd_q) begin
                            o_Dato_Leido <= i_Bus_Datos_E;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    o_Ocupado <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_bus_param.sv
// Scoreboard bench for control_bus_param: randomized transactions
// against a cycle-count reference model, plus directed reset checks.
module tb_control_bus_param;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 15;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          i_Inicio = 1'b0;
    logic [1:0]    Control_Salida = 2'b00;
    logic [DW-1:0] Num8b = '0;
    logic [DW-1:0] RX = '0;
    logic [DW-1:0] RY = '0;
    logic          i_Listo = 1'b0;
    logic [DW-1:0] i_Bus_Datos_E = '0;
    logic [DW-1:0] o_Bus_Datos_S;
    logic [AW-1:0] o_Bus_Direccion_Datos;
    logic          o_Lectura_Escritura;
    logic          o_Habilitacion;
    logic          o_Ocupado;
    logic          o_Hecho;
    logic          o_Error;
    logic [DW-1:0] o_Dato_Leido;

    control_bus_param #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .Clk                   (Clk),
        .Rst                   (Rst),
        .i_Inicio              (i_Inicio),
        .Control_Salida        (Control_Salida),
        .Num8b                 (Num8b),
        .RX                    (RX),
        .RY                    (RY),
        .i_Listo               (i_Listo),
        .i_Bus_Datos_E         (i_Bus_Datos_E),
        .o_Bus_Datos_S         (o_Bus_Datos_S),
        .o_Bus_Direccion_Datos (o_Bus_Direccion_Datos),
        .o_Lectura_Escritura   (o_Lectura_Escritura),
        .o_Habilitacion        (o_Habilitacion),
        .o_Ocupado             (o_Ocupado),
        .o_Hecho               (o_Hecho),
        .o_Error               (o_Error),
        .o_Dato_Leido          (o_Dato_Leido)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int            cycles;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rw;
        logic          err;
        logic [DW-1:0] dato;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] model_dato = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {3'b0, o_Bus_Datos_S, o_Bus_Direccion_Datos,
                o_Lectura_Escritura, o_Habilitacion, o_Ocupado,
                o_Hecho, o_Error, o_Dato_Leido};
    endfunction

    task automatic rand_ops();
        Num8b = DW'($urandom);
        RX    = DW'($urandom);
        RY    = DW'($urandom);
    endtask

    // d = number of ACCESS cycles with ready low before ready rises.
    task automatic do_txn(input logic [1:0] mode, input logic [DW-1:0] num,
                          input logic [DW-1:0] rx, input logic [DW-1:0] ry,
                          input logic [DW-1:0] rd, input int d);
        exp_t e;
        @(negedge Clk);
        i_Inicio       = 1'b1;
        Control_Salida = mode;
        Num8b          = num;
        RX             = rx;
        RY             = ry;
        i_Listo        = 1'($urandom);
        i_Bus_Datos_E  = DW'($urandom);
        if (mode == 2'b00) begin
            @(posedge Clk);
            @(negedge Clk);
            i_Inicio = 1'b0;
            chk("mode00_ignored", all_out(), {24'b0, model_dato});
            return;
        end
        e.err    = (d >= TO);
        e.cycles = e.err ? TO : d + 1;
        e.rw     = mode[1];
        e.addr   = AW'((mode == 2'b01) ? ry : rx);
        e.data   = (mode == 2'b10) ? num : (mode == 2'b11) ? ry : '0;
        if (mode == 2'b01 && !e.err) model_dato = rd;
        e.dato = model_dato;
        sb.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        chk("setup_phase", {o_Ocupado, o_Habilitacion, o_Bus_Direccion_Datos},
            {1'b1, 1'b0, e.addr});
        i_Inicio       = 1'($urandom);
        Control_Salida = 2'($urandom);
        i_Listo        = 1'($urandom);
        rand_ops();
        @(posedge Clk);
        for (int k = 0; k < e.cycles; k++) begin
            @(negedge Clk);
            i_Listo        = (k >= d);
            i_Bus_Datos_E  = (k >= d) ? rd : DW'($urandom);
            i_Inicio       = 1'($urandom);
            Control_Salida = 2'($urandom);
            rand_ops();
            @(posedge Clk);
        end
        @(negedge Clk);
        i_Inicio = 1'b0;
        i_Listo  = 1'($urandom);
        @(posedge Clk);
    endtask

    // Monitor: counts strobe cycles and scores each done pulse.
    initial begin
        int            hab_cnt;
        logic [AW-1:0] a;
        logic [DW-1:0] dt;
        logic          rw;
        exp_t          e;
        hab_cnt = 0;
        a = '0;
        dt = '0;
        rw = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                hab_cnt = 0;
            end else begin
                if (o_Habilitacion) begin
                    hab_cnt++;
                    a  = o_Bus_Direccion_Datos;
                    dt = o_Bus_Datos_S;
                    rw = o_Lectura_Escritura;
                end
                if (!o_Hecho) begin
                    chk("error_outside_done", 32'(o_Error), 32'd0);
                end else if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_cycles", hab_cnt, e.cycles);
                    chk("access_addr", 32'(a), 32'(e.addr));
                    chk("access_data", 32'(dt), 32'(e.data));
                    chk("access_rw", 32'(rw), 32'(e.rw));
                    chk("done_error", 32'(o_Error), 32'(e.err));
                    chk("done_dato", 32'(o_Dato_Leido), 32'(e.dato));
                    chk("done_bus_idle", {o_Bus_Datos_S, o_Bus_Direccion_Datos,
                        o_Lectura_Escritura, o_Habilitacion, o_Ocupado}, 32'd1);
                    hab_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int md;
        #1;
        chk("reset_outputs", all_out(), 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;

        do_txn(2'b10, 8'd3, 8'd15, 8'd0, 8'd0, 0);
        do_txn(2'b11, 8'd7, 8'd15, 8'd1, 8'd0, 3);
        do_txn(2'b01, 8'd0, 8'd9, 8'd1, 8'hA5, 0);
        do_txn(2'b10, 8'd4, 8'd2, 8'd0, 8'd0, 100);
        do_txn(2'b01, 8'd0, 8'd0, 8'd3, 8'h3C, 40);
        do_txn(2'b11, 8'd0, 8'd8, 8'd6, 8'd0, TO - 1);
        do_txn(2'b01, 8'd0, 8'd0, 8'd4, 8'h5A, TO - 1);
        do_txn(2'b00, 8'd1, 8'd2, 8'd3, 8'd0, 0);

        // Asynchronous reset while the strobe is up.
        @(negedge Clk);
        i_Inicio       = 1'b1;
        Control_Salida = 2'b10;
        i_Listo        = 1'b0;
        @(negedge Clk);
        i_Inicio = 1'b0;
        repeat (3) @(negedge Clk);
        #2;
        Rst = 1'b0;
        model_dato = '0;
        #1;
        chk("async_reset_outputs", all_out(), 32'd0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        do_txn(2'b01, 8'd0, 8'd0, 8'd7, 8'hC3, 2);

        for (int n = 0; n < 60; n++) begin
            md = (n % 10 == 9) ? 0 : $urandom_range(1, 3);
            do_txn(2'(md), DW'($urandom), DW'($urandom), DW'($urandom),
                   DW'($urandom), ($urandom_range(0, 3) == 0) ?
                   $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 6));
        end

        repeat (4) @(negedge Clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_bus_param.md
CONTROL_BUS_PARAM -- requirements
Module: control_bus_param

Interface
REQ-001 Parameter DATA_W, default 8: width of data bus, Num8b, RX, RY, read data.
REQ-002 Parameter ADDR_W, default 8: width of address bus.
REQ-003 Parameter TIMEOUT, default 15, legal range >=1: maximum ACCESS cycles before an error is flagged.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: Clk, rising edge; Rst, active-low, asynchronous assert.
REQ-005 Clk  in  1  system clock.
REQ-006 Rst  in  1  asynchronous active-low reset.
REQ-007 i_Inicio  in  1  start strobe, sampled in IDLE only.
REQ-008 Control_Salida  in  2  mode: 00 none, 01 read at RY, 10 write Num8b at RX, 11 write RY at RX.
REQ-009 Num8b, RX, RY  in  DATA_W each  operands.
REQ-010 i_Listo  in  1  memory/peripheral ready.
REQ-011 i_Bus_Datos_E  in  DATA_W  read data from bus.
REQ-012 o_Bus_Datos_S  out  DATA_W  write data.
REQ-013 o_Bus_Direccion_Datos  out  ADDR_W  address.
REQ-014 o_Lectura_Escritura  out  1  1 = write, 0 = read/idle.
REQ-015 o_Habilitacion  out  1  bus strobe.
REQ-016 o_Ocupado, o_Hecho, o_Error  out  1 each  busy, done pulse, timeout flag.
REQ-017 o_Dato_Leido  out  DATA_W  last successfully read data.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; encoding free.
REQ-019 IDLE: o_Ocupado=0, bus outputs 0; i_Inicio=1 with mode!=00 latches mode, operands, address -> SETUP; mode 00 ignored, no o_Hecho.
REQ-020 Operands SHALL be sampled only at the latch edge; later input changes have no effect on the transaction.
REQ-021 Address SHALL be low ADDR_W bits of RX (writes) or RY (read), zero-extended when ADDR_W>DATA_W.
REQ-022 SETUP (exactly 1 cycle): address, o_Lectura_Escritura, write data driven, o_Habilitacion=0, i_Listo ignored -> ACCESS.
REQ-023 ACCESS: o_Habilitacion=1, outputs held; cycle counter (width clog2(TIMEOUT+1)) increments each cycle.
REQ-024 ACCESS with i_Listo=1 -> DONE; read mode captures i_Bus_Datos_E into o_Dato_Leido on that edge.
REQ-025 ACCESS count reaching TIMEOUT without i_Listo -> DONE with error; i_Listo on the same edge as timeout wins, no error.
REQ-026 DONE (exactly 1 cycle): o_Hecho=1, o_Error valid (1 only on timeout), bus outputs 0, o_Habilitacion=0 -> IDLE.
REQ-027 o_Ocupado=1 in SETUP, ACCESS, DONE; i_Inicio while busy SHALL be ignored, not queued.
REQ-028 Minimum transaction (i_Listo high) SHALL be: latch edge, SETUP, ACCESS, DONE, i.e. o_Hecho high in the 3rd cycle after the latch edge; back-to-back start possible in the cycle after DONE.
REQ-029 Read mode: o_Bus_Datos_S=0, o_Lectura_Escritura=0; timed-out read SHALL leave o_Dato_Leido unchanged.
REQ-030 o_Error SHALL be 0 outside DONE.

Reset
REQ-031 Rst=0 SHALL immediately force IDLE, counter 0, all outputs 0 including o_Dato_Leido, independent of Clk.
REQ-032 Reset mid-transaction SHALL abort with no o_Hecho; first start accepted at first rising edge with Rst=1.

Verification
REQ-033 Mode 10, Num8b=3, RX=15, i_Listo=1 -> SETUP/ACCESS: addr=15, data=3, R/W=1; o_Hecho 1 cycle, o_Error=0.
REQ-034 Mode 11, RX=15, RY=1, i_Listo held 0 for 3 ACCESS cycles then 1 -> strobe high 4 cycles, addr=15, data=1, no error.
REQ-035 Mode 01, RY=1, i_Bus_Datos_E=0xA5, i_Listo=1 -> addr=1, R/W=0, o_Dato_Leido=0xA5 from DONE onward.
REQ-036 Any write, i_Listo=0, TIMEOUT=15 -> 15 ACCESS cycles, DONE with o_Hecho=1, o_Error=1; o_Dato_Leido unchanged.
REQ-037 Mode 00 with i_Inicio=1 -> stays IDLE, outputs 0; second i_Inicio during a busy transaction -> ignored.
REQ-038 Rst=0 during ACCESS -> all outputs 0 without clock edge, no o_Hecho; new start after release completes normally.
